// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the shared data-memory arbiter.
// Holds the FSM state encoding and the parameter defaults used by the arbiter and its picker.
package dmem_arbiter_pkg;

  localparam int DEF_CORE_COUNT  = 4;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH  = 12;
  localparam int DEF_MEM_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first requesting core found
// searching upward from (last_grant+1) mod N with wrap-around.
module rr_picker
  import dmem_arbiter_pkg::*;
#(
  parameter  int N  = DEF_CORE_COUNT,
  localparam int GW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic          valid,
  output logic [GW-1:0] grant_idx
);

  int w_dist;
  int w_best;

  // Each core's distance from last_grant+1 on the ring; the smallest requesting distance wins.
  always_comb begin
    valid     = |req;
    grant_idx = '0;
    w_dist    = 0;
    w_best    = N;
    for (int i = 0; i < N; i++) begin
      w_dist = (i + 2 * N - 1 - int'(last_grant)) % N;
      if (req[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        grant_idx = GW'(i);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving several cores single-transaction access to one shared RAM.
// Handshake: a core raises req with addr/wrEn/wrData and holds them until its one-cycle ack.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter  int CORE_COUNT  = DEF_CORE_COUNT,
  parameter  int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter  int MEM_LATENCY = DEF_MEM_LATENCY,
  localparam int GW          = idx_width(CORE_COUNT),
  localparam int LW          = idx_width(MEM_LATENCY + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CORE_COUNT-1:0]            core_req,
  input  logic [CORE_COUNT-1:0]            core_wrEn,
  input  logic [CORE_COUNT*ADDR_WIDTH-1:0] core_addr,
  input  logic [CORE_COUNT*DATA_WIDTH-1:0] core_wrData,
  output logic [CORE_COUNT-1:0]            core_ack,
  output logic [DATA_WIDTH-1:0]            core_rdData,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_wrEn,
  output logic [DATA_WIDTH-1:0]            mem_wrData,
  input  logic [DATA_WIDTH-1:0]            mem_rdData,
  output logic [GW-1:0]                    grant_id,
  output logic                             busy,
  output logic [1:0]                       o_dbg_state
);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [LW-1:0]         r_lat_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wrData;
  logic                  r_mem_wrEn;
  logic [GW-1:0]         r_grant_id;
  logic [GW-1:0]         r_last_grant;

  logic                  w_valid;
  logic [GW-1:0]         w_pick;
  logic                  w_load;
  logic                  w_lat_done;
  logic [ADDR_WIDTH-1:0] w_addr_arr   [CORE_COUNT];
  logic [DATA_WIDTH-1:0] w_wrData_arr [CORE_COUNT];

  for (genvar g = 0; g < CORE_COUNT; g++) begin : g_unpack
    assign w_addr_arr[g]   = core_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wrData_arr[g] = core_wrData[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(
    .N (CORE_COUNT)
  ) u_picker (
    .req        (core_req),
    .last_grant (r_last_grant),
    .valid      (w_valid),
    .grant_idx  (w_pick)
  );

  assign w_lat_done = (r_lat_cnt == LW'(MEM_LATENCY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    core_ack    = '0;
    core_rdData = '0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (w_lat_done) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        core_ack[r_grant_id] = 1'b1;
        core_rdData          = mem_rdData;
        w_state_nxt          = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The write strobe is set only on the grant edge, so it lives for the first ACCESS cycle alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat_cnt    <= '0;
      r_mem_addr   <= '0;
      r_mem_wrData <= '0;
      r_mem_wrEn   <= 1'b0;
      r_grant_id   <= '0;
      r_last_grant <= GW'(CORE_COUNT - 1);
    end else if (w_load) begin
      r_lat_cnt    <= '0;
      r_mem_addr   <= w_addr_arr[w_pick];
      r_mem_wrData <= w_wrData_arr[w_pick];
      r_mem_wrEn   <= core_wrEn[w_pick];
      r_grant_id   <= w_pick;
      r_last_grant <= w_pick;
    end else begin
      r_mem_wrEn <= 1'b0;
      if (r_state == ACCESS) begin
        r_lat_cnt <= r_lat_cnt + 1'b1;
      end
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_wrData  = r_mem_wrData;
  assign mem_wrEn    = r_mem_wrEn;
  assign grant_id    = r_grant_id;
  assign busy        = (r_state != IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter CORE_COUNT, default 4: number of requesting cores, legal range 2..16.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8: shared data-memory address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 12: memory word width.
REQ-004 SHALL have parameter MEM_LATENCY, default 1: cycles from mem_addr valid to mem_rdData valid, legal range 1..4.
REQ-005 SHALL have port clk  in  1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-007 SHALL have port core_req  in  CORE_COUNT: per-core access request; bit i belongs to core i.
REQ-008 SHALL have port core_wrEn  in  CORE_COUNT: per-core operation, 1 = write, 0 = read.
REQ-009 SHALL have port core_addr  in  CORE_COUNT*ADDR_WIDTH: packed per-core address; core i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port core_wrData  in  CORE_COUNT*DATA_WIDTH: packed per-core write data, packed the same way as core_addr.
REQ-011 SHALL have port core_ack  out  CORE_COUNT: one-cycle completion pulse to the granted core.
REQ-012 SHALL have port core_rdData  out  DATA_WIDTH: read data broadcast to all cores; qualified by core_ack.
REQ-013 SHALL have port mem_addr  out  ADDR_WIDTH: registered address to the shared RAM.
REQ-014 SHALL have port mem_wrEn  out  1: registered RAM write strobe.
REQ-015 SHALL have port mem_wrData  out  DATA_WIDTH: registered RAM write data.
REQ-016 SHALL have port mem_rdData  in  DATA_WIDTH: RAM read data.
REQ-017 SHALL have port grant_id  out  $clog2(CORE_COUNT): index of the current or last granted core.
REQ-018 SHALL have port busy  out  1: high in any state other than IDLE.

Function
REQ-019 SHALL implement an FSM with states IDLE, ACCESS and RESP.
REQ-020 In IDLE with any core_req bit set, SHALL pick exactly one core by round-robin, searching upward from (last_grant+1) mod CORE_COUNT with wrap-around.
REQ-021 In the same IDLE cycle, SHALL register the winner's addr, wrData and wrEn into mem_addr, mem_wrData and mem_wrEn, update grant_id and last_grant, and enter ACCESS.
REQ-022 SHALL stay in ACCESS for exactly MEM_LATENCY cycles, counted by a latency counter, then enter RESP.
REQ-023 SHALL assert mem_wrEn only during the first ACCESS cycle, and only for a write.
REQ-024 In RESP, SHALL drive core_rdData = mem_rdData, pulse core_ack[grant_id] for exactly one cycle and return to IDLE; total latency from grant edge to ack is MEM_LATENCY+1 cycles.
REQ-025 SHALL pulse core_ack for writes with the same timing as reads; core_rdData is don't-care on write acks.
REQ-026 SHALL require requesters to hold req, addr, wrEn and wrData stable until ack; requests arriving while busy=1 SHALL wait and are not lost while held.
REQ-027 SHALL make a request deasserted before it is granted produce no access.
REQ-028 SHALL complete a granted transaction and pulse its ack even if the request is deasserted after the grant.
REQ-029 SHALL keep at most one transaction in flight; an idle cycle between transactions is mandatory, giving a throughput of one access per MEM_LATENCY+2 cycles.
REQ-030 SHALL drive core_ack to all zeros whenever the state is not RESP.

Reset
REQ-031 SHALL, when rst is asserted, immediately force state IDLE, latency counter 0, core_ack 0, mem_wrEn 0, mem_addr 0, mem_wrData 0, core_rdData 0, grant_id 0, busy 0, and last_grant CORE_COUNT-1, so that core 0 has first priority.
REQ-032 SHALL abort any in-flight transaction when rst is asserted mid-operation, with no ack issued; a write strobe not yet sampled by the RAM is lost.

Structure
REQ-033 SHALL take the state enum typedef (arb_state_t) and the parameter defaults from the shared package dmem_arbiter_pkg.
REQ-034 SHALL place the round-robin search in one combinational sub-module, rr_picker (inputs req and last_grant; outputs valid and grant_idx).

Verification
REQ-035 The bench SHALL check reset: after rst, with core_req=4'b1111, grants go to 0, 1, 2, 3 in that order.
REQ-036 The bench SHALL check a single read: core 2 reads addr 8'h15 with the RAM holding 12'hABC at that address -> core_ack=4'b0100 exactly 2 cycles after the grant edge (MEM_LATENCY=1), with core_rdData=12'hABC.
REQ-037 The bench SHALL check a write then read: core 1 writes 12'h5A5 to 8'h03, then core 3 reads 8'h03 -> exactly one mem_wrEn pulse occurs and core 3 receives 12'h5A5.
REQ-038 The bench SHALL check wrap-around: with last_grant=3 and core_req=4'b1001 -> the grant goes to core 0, and the next grant goes to core 3.
REQ-039 The bench SHALL check reset mid-operation: rst is asserted during ACCESS of core 1's write -> core_ack stays 0, busy drops at once, and the next grant after reset goes to core 0.
REQ-040 The bench SHALL check latency scaling: with MEM_LATENCY=3 -> ack comes 4 cycles after the grant, and busy is high for 4 cycles per transaction.
